uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Transmit side of the UART link. Accepts a parallel byte with a one-cycle valid strobe and serialises it onto `tx_out` as a standard UART frame: start bit, 8 data bits LSB first, optional parity, stop bit. Each bit is held for `prescale` clock cycles, matching the oversampling ratio the receive path uses. It sits between the system register/FIFO side and the serial pin, in the same clock domain as the frame generator that feeds it.

## Interface
Parameters:
- `DATA_WIDTH`, 8, payload bits per frame.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `p_data` in DATA_WIDTH: parallel byte to send, sampled only on acceptance.
- `data_valid` in 1: request strobe; accepted only when `busy`=0.
- `par_en` in 1: 1 = parity bit inserted after data.
- `par_typ` in 1: 0 = even parity, 1 = odd parity.
- `prescale` in 6: clock cycles per bit; 0 is treated as 1.
- `tx_out` out 1: serial line, idles high.
- `busy` out 1: high from acceptance through the last stop-bit cycle.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Acceptance (IDLE, `data_valid`=1):**
  - Latch `p_data`, `par_en`, `par_typ` and the effective prescale (max(prescale,1)).
  - Compute parity from the latched byte: even = XOR of the bits; odd = inverted XOR.
  - Go to START.
- **Input sampling:** inputs are sampled only at acceptance. Later changes to `p_data`, `par_en`, `par_typ` or `prescale` do not affect the frame in flight.
- **Bit counter:** a 6-bit counter runs 0..P-1, where P is the latched prescale. At P-1 the bit ends and the counter wraps to 0.
- **Transitions at bit end:**
  - START -> DATA.
  - DATA advances a 3-bit index 0..7. After index 7 it goes to PARITY if `par_en`, else to STOP.
  - PARITY -> STOP.
  - STOP -> IDLE.
- **Line values per state:**
  - IDLE = 1.
  - START = 0.
  - DATA = latched bit[index].
  - PARITY = latched parity.
  - STOP = 1.
- **`data_valid` while `busy`=1:** ignored, not queued. The source must hold or re-present the request.
- **Reset (`rst_n`=0 at a rising edge), including mid-frame:**
  - Next state IDLE; `tx_out`=1, `busy`=0.
  - Counters and latches cleared.
  - The partial frame is abandoned; no stop bit is forced.
- **Simultaneous reset and `data_valid`:** reset wins; nothing is accepted.

## Timing
- **Outputs are registered.** Reset values: `tx_out`=1, `busy`=0.
- **Acceptance edge N** (IDLE, `data_valid`=1): after edge N, `tx_out`=0 and `busy`=1. That is one cycle of latency from strobe to start bit.
- **Frame length:** P×10 cycles without parity, P×11 with parity. `busy` is high for exactly that many cycles.
- **End of frame:** after the last STOP cycle, `busy`=0 and `tx_out`=1 on the same edge.
- **Next frame:** the earliest new acceptance is the following edge, giving a minimum 1-cycle idle gap (line high) between frames.
- **Bit boundaries** are exact multiples of P cycles from the start-bit edge. There is no jitter or stretch.

## Test plan
- **Even parity, prescale 8:** `p_data`=0xA5, `par_en`=1, `par_typ`=0, `prescale`=8.
  - Line sequence, 8 cycles each: 0; 1,0,1,0,0,1,0,1; 0; 1.
  - `busy` high for 88 cycles.
- **Odd parity, prescale 16:** `p_data`=0x01, `par_en`=1, `par_typ`=1, `prescale`=16.
  - Data bits 1,0,0,0,0,0,0,0; parity 0.
  - `busy` high for 176 cycles.
- **No parity, prescale 0:** `p_data`=0xFF, `par_en`=0, `prescale`=0.
  - Bit period is 1 cycle: 0, then eight 1s, then stop 1.
  - `busy` high for exactly 10 cycles.
- **Back-to-back and ignored request:** start frame 0x3C at prescale 8, then pulse `data_valid` with 0x99 at cycle 20.
  - The 0x3C frame is unchanged; no second frame is sent.
  - Re-strobe 0x99 one cycle after `busy` falls: its start bit begins on the next cycle.
- **Reset mid-frame:** drive `rst_n`=0 for 1 cycle at cycle 30 of a prescale-8 frame.
  - Next cycle: `tx_out`=1, `busy`=0.
  - A new 0x5A request is then accepted and sent correctly.
- **Input stability:** change `p_data`, `par_typ` and `prescale` every cycle during a frame.
  - The transmitted bits, parity and bit period match the values latched at acceptance.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first,
// optional even/odd parity, one stop bit, each bit held for `prescale` cycles.
// Ports: clk/rst_n (sync, active-low); p_data/data_valid request (taken only
// when idle); par_en/par_typ parity control; prescale cycles per bit (0 acts
// as 1); tx_out registered serial line (idles high); busy high for the frame.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [5:0]            prescale,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  parity_q, parity_d;
  logic [5:0]            presc_q, presc_d;
  logic                  tx_d, busy_d;
  logic                  bit_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      presc_q  <= '0;
      tx_out   <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      par_en_q <= par_en_d;
      parity_q <= parity_d;
      presc_q  <= presc_d;
      tx_out   <= tx_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    par_en_d = par_en_q;
    parity_d = parity_q;
    presc_d  = presc_q;
    tx_d     = 1'b1;
    busy_d   = 1'b0;
    // presc_q is at least 1 whenever this is consulted (outside IDLE)
    bit_end  = (cnt_q == (presc_q - 6'd1));

    if (state_q == IDLE) begin
      if (data_valid) begin
        data_d   = p_data;
        par_en_d = par_en;
        // even parity = XOR of data; odd parity = its inverse
        parity_d = par_typ ^ (^p_data);
        presc_d  = (prescale == 6'd0) ? 6'd1 : prescale;
        cnt_d    = '0;
        idx_d    = '0;
        state_d  = START;
      end
    end else begin
      cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
      if (bit_end) begin
        case (state_q)
          START:   state_d = DATA;
          DATA: begin
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = par_en_q ? PARITY : STOP;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
          PARITY:  state_d = STOP;
          STOP:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end

    // Outputs are decoded from the next state so they register in step with it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic exp_q[$];
  logic got_q[$];

  uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference: list the frame's bits from the UART rules, then stretch each
  // bit over the effective bit period to get the per-cycle line value.
  task automatic build_expected(input logic [7:0] d, input logic pe, input logic pt,
                                input logic [5:0] ps);
    logic bits[$];
    int   eff;
    int   ones;
    eff  = (ps == 0) ? 1 : int'(ps);
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    bits.push_back(1'b1);
    exp_q.delete();
    foreach (bits[b])
      for (int k = 0; k < eff; k++) exp_q.push_back(bits[b]);
  endtask

  // Present a request for one cycle; returns at the negedge after acceptance.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Record tx_out each cycle while busy. Optionally churn the inputs, and
  // optionally pulse a 0x99 request at cycle poke_at of the frame.
  task automatic capture(input bit scramble, input int poke_at);
    int n = 0;
    got_q.delete();
    while (busy === 1'b1 && n < 2000) begin
      got_q.push_back(tx_out);
      if (scramble) begin
        p_data   = 8'($urandom);
        par_typ  = 1'($urandom);
        par_en   = 1'($urandom);
        prescale = 6'($urandom);
      end
      data_valid = (n == poke_at);
      if (n == poke_at) p_data = 8'h99;
      n++;
      @(negedge clk);
    end
    data_valid = 1'b0;
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout: busy still %b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_frame_case(input string name, input logic [7:0] d, input logic pe,
                                 input logic pt, input logic [5:0] ps, input int exp_len,
                                 input bit scramble);
    int bad = 0;
    build_expected(d, pe, pt, ps);
    start_frame(d, pe, pt, ps);
    capture(scramble, -1);
    checks++;
    if (got_q.size() !== exp_len) begin
      errors++;
      $display("FAIL %s busy_len: got %0d cycles, required %0d", name, got_q.size(), exp_len);
    end
    foreach (got_q[i]) begin
      checks++;
      if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        bad++;
        if (bad <= 4)
          $display("FAIL %s line cycle %0d: got %b, required %b", name, i, got_q[i],
                   (i < exp_q.size()) ? exp_q[i] : 1'bx);
      end
    end
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: tx_out=%b busy=%b, required 1/0", name, tx_out, busy);
    end
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    data_valid = 1'b1;
    p_data     = 8'hFF;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 6'd4;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: tx_out=%b busy=%b, required 1/0", tx_out, busy);
    end
    data_valid = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins_valid: tx_out=%b busy=%b, required 1/0", tx_out, busy);
    end
  endtask

  task automatic test_back_to_back;
    test_frame_case("b2b_first", 8'h3C, 1'b0, 1'b0, 6'd8, 80, 1'b0);
    build_expected(8'h3C, 1'b0, 1'b0, 6'd8);
    start_frame(8'h3C, 1'b0, 1'b0, 6'd8);
    capture(1'b0, 20);
    checks++;
    if (got_q.size() !== 80) begin
      errors++;
      $display("FAIL b2b_ignored_len: got %0d cycles, required 80", got_q.size());
    end
    foreach (got_q[i]) begin
      checks++;
      if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_ignored_line cycle %0d: got %b, required %b", i, got_q[i],
                 (i < exp_q.size()) ? exp_q[i] : 1'bx);
      end
    end
    // Re-strobe on the first idle cycle; start bit must follow immediately.
    test_frame_case("b2b_restrobe", 8'h99, 1'b0, 1'b0, 6'd8, 80, 1'b0);
  endtask

  task automatic test_reset_midframe;
    start_frame(8'hC3, 1'b1, 1'b0, 6'd8);
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: tx_out=%b busy=%b, required 1/0", tx_out, busy);
    end
    test_frame_case("after_reset", 8'h5A, 1'b1, 1'b0, 6'd8, 88, 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      logic [7:0] d;
      logic       pe, pt;
      logic [5:0] ps;
      int         eff;
      d   = 8'($urandom);
      pe  = 1'($urandom);
      pt  = 1'($urandom);
      ps  = 6'($urandom_range(0, 12));
      eff = (ps == 0) ? 1 : int'(ps);
      test_frame_case("random", d, pe, pt, ps, eff * (pe ? 11 : 10), (r % 2) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_frame_case("even_par_p8", 8'hA5, 1'b1, 1'b0, 6'd8, 88, 1'b0);
    test_frame_case("odd_par_p16", 8'h01, 1'b1, 1'b1, 6'd16, 176, 1'b0);
    test_frame_case("nopar_p0", 8'hFF, 1'b0, 1'b0, 6'd0, 10, 1'b0);
    test_back_to_back();
    test_reset_midframe();
    test_frame_case("input_stability", 8'h6D, 1'b1, 1'b1, 6'd5, 55, 1'b1);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
